// File: rtl/led_display_arbiter.sv
// Frame-aligned arbiter that shares one LED nibble display between NUM_REQ requesters.
// Round-robin by default; define LED_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module led_display_arbiter #(
    parameter int          NUM_REQ    = 4,
    parameter int          MIN_FRAMES = 1,
    parameter logic [31:0] IDLE_VALUE = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_tick,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [32*NUM_REQ-1:0]   values,
    output logic [31:0]             value,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      done,
    output logic                    busy
);
    // state | meaning
    // IDLE  | nothing granted, display shows IDLE_VALUE
    // HOLD  | one requester owns the display for MIN_FRAMES frames

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (MIN_FRAMES > 0) ? $clog2(MIN_FRAMES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MIN_FRAMES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [31:0]          value_q, value_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        start;
    logic [IW-1:0]        win;
    logic [IW-1:0]        idx;
    logic                 found;
    logic [31:0]          win_value;

`ifdef LED_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [IW-1:0]        ptr_q, ptr_d;
    assign start = ptr_q;
`endif

    // Walk from the farthest offset down so the nearest requester to start wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(start) + k) % NUM_REQ);
            if (req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_value = IDLE_VALUE;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (k == int'(win)) win_value = values[32*k +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            value_q <= IDLE_VALUE;
            cnt_q   <= '0;
`ifndef LED_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            value_q <= value_d;
            cnt_q   <= cnt_d;
`ifndef LED_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        value_d = value_q;
        cnt_d   = cnt_q;
`ifndef LED_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        if (frame_tick) begin
            // A hold that ends on this tick frees the display for re-arbitration.
            if (state_q == HOLD && cnt_q > CNT_ONE) begin
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                if (state_q == HOLD) done_d = grant_q;
                if (found) begin
                    state_d = HOLD;
                    grant_d = NUM_REQ'(1) << win;
                    value_d = win_value;
                    cnt_d   = CNT_LOAD;
`ifndef LED_ARB_FIXED_PRIO_EN
                    ptr_d   = IW'((int'(win) + 1) % NUM_REQ);
`endif
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    value_d = IDLE_VALUE;
                    cnt_d   = '0;
                end
            end
        end
    end

    assign value = value_q;
    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = (state_q == HOLD);

endmodule

// File: tb/tb_led_display_arbiter.sv
// Directed bench for led_display_arbiter: instance a holds 2 frames, instance b holds 1 frame.
// Expectations follow LED_ARB_FIXED_PRIO_EN when the bench is built with it.
module tb_led_display_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         frame_tick = 1'b0;
    logic [3:0]   req_a = '0, req_b = '0;
    logic [127:0] values_a = '0, values_b = '0;
    logic [31:0]  value_a, value_b;
    logic [3:0]   grant_a, grant_b, done_a, done_b;
    logic         busy_a, busy_b;
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    led_display_arbiter #(.NUM_REQ(4), .MIN_FRAMES(2), .IDLE_VALUE(32'h0)) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .req(req_a), .values(values_a),
        .value(value_a), .grant(grant_a), .done(done_a), .busy(busy_a));

    led_display_arbiter #(.NUM_REQ(4), .MIN_FRAMES(1), .IDLE_VALUE(32'h0)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .req(req_b), .values(values_b),
        .value(value_b), .grant(grant_b), .done(done_b), .busy(busy_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered just after a negedge; returns at the next negedge with outputs settled.
    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
    endtask

    task automatic chk_a(input string tag, input logic [3:0] g, input logic [31:0] v,
                         input logic [3:0] d, input logic b);
        chk({tag, ".grant"}, 32'(grant_a), 32'(g));
        chk({tag, ".value"}, value_a, v);
        chk({tag, ".done"},  32'(done_a), 32'(d));
        chk({tag, ".busy"},  32'(busy_a), 32'(b));
    endtask

    task automatic chk_b(input string tag, input logic [3:0] g, input logic [31:0] v,
                         input logic [3:0] d);
        chk({tag, ".grant"}, 32'(grant_b), 32'(g));
        chk({tag, ".value"}, value_b, v);
        chk({tag, ".done"},  32'(done_b), 32'(d));
    endtask

    initial begin
        int exp_idx, prev_idx;
        for (int k = 0; k < 4; k++) values_b[32*k +: 32] = 32'hBBBB_0000 + 32'(k);

        // Reset state
        repeat (2) @(negedge clk);
        chk_a("rst", 4'b0000, 32'h0, 4'b0000, 1'b0);
        chk_b("rst_b", 4'b0000, 32'h0, 4'b0000);
        rst_n = 1'b1;
        idle_cycle();

        // No requests: ticks leave the arbiter idle
        tick();
        chk_a("idle_t1", 4'b0000, 32'h0, 4'b0000, 1'b0);
        tick();
        chk_a("idle_t2", 4'b0000, 32'h0, 4'b0000, 1'b0);

        // Request between ticks is not acted on until the tick
        values_a[64 +: 32] = 32'hDEAD_BEEF;
        req_a = 4'b0100;
        idle_cycle();
        chk_a("no_tick", 4'b0000, 32'h0, 4'b0000, 1'b0);
        tick();
        chk_a("g2_t1", 4'b0100, 32'hDEAD_BEEF, 4'b0000, 1'b1);
        req_a = 4'b0000;
        idle_cycle();
        tick();
        chk_a("g2_t2", 4'b0100, 32'hDEAD_BEEF, 4'b0000, 1'b1);
        idle_cycle();
        tick();
        chk_a("g2_t3", 4'b0000, 32'h0, 4'b0100, 1'b0);
        idle_cycle();
        chk_a("g2_after", 4'b0000, 32'h0, 4'b0000, 1'b0);

        // Snapshot is frozen for the hold
        values_a[32 +: 32] = 32'h1234_5678;
        req_a = 4'b0010;
        tick();
        chk_a("snap_t1", 4'b0010, 32'h1234_5678, 4'b0000, 1'b1);
        values_a[32 +: 32] = 32'hFFFF_FFFF;
        idle_cycle();
        chk_a("snap_mid", 4'b0010, 32'h1234_5678, 4'b0000, 1'b1);
        tick();
        chk_a("snap_t2", 4'b0010, 32'h1234_5678, 4'b0000, 1'b1);
        tick();
        chk_a("snap_regrant", 4'b0010, 32'hFFFF_FFFF, 4'b0010, 1'b1);
        req_a = 4'b0000;
        tick();
        tick();
        chk_a("snap_end", 4'b0000, 32'h0, 4'b0010, 1'b0);
        idle_cycle();

        // Asynchronous reset mid-hold, no done pulse
        values_a[31:0] = 32'hA5A5_0001;
        req_a = 4'b0001;
        tick();
        chk_a("rh_grant", 4'b0001, 32'hA5A5_0001, 4'b0000, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_a("rh_async", 4'b0000, 32'h0, 4'b0000, 1'b0);
        req_a = 4'b0000;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk_a("rh_held", 4'b0000, 32'h0, 4'b0000, 1'b0);
        rst_n = 1'b1;
        idle_cycle();

        // All requesting with one-frame holds: rotation (or fixed priority)
        req_b = 4'b1111;
        prev_idx = -1;
        for (int i = 0; i < 8; i++) begin
`ifdef LED_ARB_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = i % 4;
`endif
            tick();
            chk_b($sformatf("rot%0d", i), 4'b0001 << exp_idx, 32'hBBBB_0000 + 32'(exp_idx),
                  (prev_idx < 0) ? 4'b0000 : (4'b0001 << prev_idx));
            chk("rot_busy", 32'(busy_b), 32'h1);
            idle_cycle();
            chk("rot_done_clr", 32'(done_b), 32'h0);
            prev_idx = exp_idx;
        end
        req_b = 4'b0000;
        tick();
        chk_b("rot_end", 4'b0000, 32'h0, 4'b0001 << prev_idx);
        idle_cycle();

        // Owner drops req right after grant; pending req[3] takes over with the done pulse
        req_b = 4'b0001;
        tick();
        chk_b("drop_grant", 4'b0001, 32'hBBBB_0000, 4'b0000);
        req_b = 4'b1000;
        idle_cycle();
        chk_b("drop_persist", 4'b0001, 32'hBBBB_0000, 4'b0000);
        tick();
        chk_b("drop_handover", 4'b1000, 32'hBBBB_0003, 4'b0001);
        req_b = 4'b0000;
        tick();
        chk_b("drop_end", 4'b0000, 32'h0, 4'b1000);
        chk("drop_busy", 32'(busy_b), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/led_display_arbiter.md
# led_display_arbiter

Shares the single LED nibble display between up to `NUM_REQ` requesters, each offering a 32-bit value. The block sits in front of the display's `value` input and switches ownership only on display frame boundaries (one frame = all 8 nibbles shown), so every granted value is always shown as complete frames. Round-robin by default; fixed priority when configured.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `MIN_FRAMES`, 1: complete frames each grant is held; must be ≥1.
- `IDLE_VALUE`, 32'h0000_0000: value driven when nothing is granted.

- `clk` input 1: 12 MHz system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `frame_tick` input 1: one-cycle pulse marking a display frame boundary (MSB nibble about to be shown).
- `req` input NUM_REQ: level request per requester.
- `values` input 32*NUM_REQ: requester i's value at bits [32*i+31:32*i].
- `value` output 32: value fed to the display.
- `grant` output NUM_REQ: one-hot owner, or all-zero when idle.
- `done` output NUM_REQ: one-cycle pulse to the owner when its hold completes.
- `busy` output 1: high while in HOLD.

## Operation
- State machine, two states:
  - IDLE: `grant`=0, `value`=IDLE_VALUE, `busy`=0.
  - HOLD: `grant` one-hot, `value` = snapshot of the owner's `values` slice.
- Arbitration is evaluated only in a cycle with `frame_tick`=1. `req` activity between ticks is not acted on until the next tick.
- IDLE, tick, any `req` set: select the winner, snapshot its value, load the frame counter with MIN_FRAMES, and enter HOLD.
- IDLE, tick, no `req` set: remain in IDLE.
- HOLD, tick: decrement the frame counter.
  - Counter not reaching 0: stay in HOLD.
  - Counter reaching 0: pulse `done[owner]`, then re-arbitrate in the same cycle.
    - Winner found: new grant, new snapshot, counter reloaded, stay in HOLD.
    - No winner: go to IDLE.
- Round-robin: search starts at (last owner + 1) mod NUM_REQ and wraps. The current owner is eligible again, but only after all other requesters. After reset the search starts at index 0.
- The snapshot is taken once, at grant time. Changes to `values` during the hold are ignored.
- Deasserting `req` mid-hold does not abort. The grant runs to completion and `done` still pulses.
- The frame counter is $clog2(MIN_FRAMES+1) bits and never underflows.

## Timing
- All outputs are registered. They change on the clock edge that samples `frame_tick`=1, so they are visible the cycle after the tick.
- `done` is high for exactly one cycle, coincident with the grant change.
- Grant handover is back-to-back: no idle frame is inserted between owners when a request is pending.
- Worst-case wait for requester i = (NUM_REQ−1)·MIN_FRAMES frames + 1 frame of tick alignment.
- Reset (asynchronous assert, any state including mid-hold):
  - `grant`=0, `value`=IDLE_VALUE, `done`=0, `busy`=0.
  - State IDLE, round-robin pointer at index 0.
  - No `done` pulse is issued for the aborted hold.
- `frame_tick` held high for consecutive cycles counts as one tick per cycle. The integrator guarantees single-cycle pulses.

## Configuration
- `LED_ARB_FIXED_PRIO_EN` defined: fixed priority, where the lowest-index asserted `req` always wins at each arbitration point. The round-robin pointer is not implemented.
- Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then `req`=4'b0000 with ticks → `grant`=0, `value`=32'h0 and `busy`=0 throughout. Assert `rst_n`=0 mid-hold → outputs reset in the same cycle, with no `done` pulse.
- `req`=4'b0100, `values[2]`=32'hDEAD_BEEF, MIN_FRAMES=2 → cycle after the 1st tick: `grant`=4'b0100 and `value`=32'hDEAD_BEEF. At the 3rd tick `done`=4'b0100 for 1 cycle, then `grant`=0.
- `req`=4'b1111 held for 8 frames (MIN_FRAMES=1) → grant sequence 0001, 0010, 0100, 1000, 0001, … with one `done` pulse per frame. With `LED_ARB_FIXED_PRIO_EN` defined, `grant` stays 4'b0001.
- Owner's `values` changes from 32'h1234_5678 to 32'hFFFF_FFFF mid-hold → `value` stays 32'h1234_5678 until the hold ends.
- Owner drops `req` one cycle after its grant → the grant persists to the frame end and `done` still pulses. A pending `req[3]` is granted in the same cycle as that `done` pulse.
